// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the carry-save accumulation controller.
// Holds the FSM state enum, default widths and the 4:2 compressor cell equations.
package csa_acc_pkg;

  localparam int unsigned CSA_ACC_WIDTH  = 32;
  localparam int unsigned CSA_ACC_BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } csa_acc_state_e;

  // 4:2 cell: full adder (x1,x2,x3) feeding a second full adder with x4 and ci.
  function automatic logic c42_co(input logic x1, input logic x2, input logic x3);
    return (x1 & x2) | (x1 & x3) | (x2 & x3);
  endfunction

  function automatic logic c42_s(input logic x1, input logic x2, input logic x3,
                                 input logic x4, input logic ci);
    return x1 ^ x2 ^ x3 ^ x4 ^ ci;
  endfunction

  function automatic logic c42_c(input logic x1, input logic x2, input logic x3,
                                 input logic x4, input logic ci);
    logic t;
    t = x1 ^ x2 ^ x3;
    return (t & x4) | (t & ci) | (x4 & ci);
  endfunction

endpackage

// File: rtl/csa_4_2_row.sv
// One WIDTH-bit row of 4:2 compressors with the ci/co chain; purely combinational.
// c_sh is the carry vector already weighted by 2 (LSB 0); the MSB co and carry drop out.
module csa_4_2_row
  import csa_acc_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_ACC_WIDTH
) (
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c_sh
);

  logic [WIDTH-1:0] ci;
  logic [WIDTH-2:0] co;

  assign ci      = {co, 1'b0};
  assign c_sh[0] = 1'b0;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign s[i] = c42_s(x1[i], x2[i], x3[i], x4[i], ci[i]);
    if (i < int'(WIDTH) - 1) begin : g_carry
      assign co[i]     = c42_co(x1[i], x2[i], x3[i]);
      assign c_sh[i+1] = c42_c(x1[i], x2[i], x3[i], x4[i], ci[i]);
    end
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulation controller: folds operand pairs through one 4:2 row, then resolves S+C.
// Optional accepted-beat count output (out_beats) is enabled with `define CSA_ACC_BEATS_EN.
module csa_accum_ctrl
  import csa_acc_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_ACC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_sum
`ifdef CSA_ACC_BEATS_EN
  ,
  output logic [CSA_ACC_BEAT_W-1:0] out_beats
`endif
);

  csa_acc_state_e   state_q, state_d;
  logic [WIDTH-1:0] s_q, c_q;
  logic [WIDTH-1:0] row_s, row_c;
  logic             accept;

  assign accept = in_valid & in_ready;

  csa_4_2_row #(.WIDTH(WIDTH)) u_row (
    .x1   (s_q),
    .x2   (c_q),
    .x3   (in_a),
    .x4   (in_b),
    .s    (row_s),
    .c_sh (row_c)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (accept) state_d = in_last ? RESOLVE : ACCUM;
      RESOLVE:     state_d = OUTPUT;
      OUTPUT:      if (out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE) || (state_d == ACCUM);
      out_valid <= (state_d == OUTPUT);
    end
  end

  // Carry-save state; the CPA only feeds out_sum in RESOLVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_q     <= '0;
      out_sum <= '0;
    end else if (state_q == RESOLVE) begin
      out_sum <= s_q + c_q;
      s_q     <= '0;
      c_q     <= '0;
    end else if (accept) begin
      s_q <= row_s;
      c_q <= row_c;
    end
  end

`ifdef CSA_ACC_BEATS_EN
  logic [CSA_ACC_BEAT_W-1:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      out_beats  <= '0;
    end else if (state_q == RESOLVE) begin
      out_beats  <= beat_cnt_q;
      beat_cnt_q <= '0;
    end else if (accept && (beat_cnt_q != '1)) begin
      beat_cnt_q <= beat_cnt_q + CSA_ACC_BEAT_W'(1);
    end
  end
`endif

endmodule
